// File: rtl/mux_pkg.sv
// ============================================================================
// Module   : mux_pkg
// Brief    : Shared mode encodings and width helper for the N:1 stream mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Keeps index widths legal when a degenerate single-channel build is tried.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin grant search starting after last_grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] last_grant,
    output logic            grant_valid,
    output logic [SELW-1:0] grant_idx
);

    // Walk the ring from farthest to nearest so the nearest requester wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = N; k >= 1; k--) begin
            idx = int'(last_grant) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = SELW'(idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_nto1_stream.sv
// ============================================================================
// Module   : mux_nto1_stream
// Brief    : N-input registered stream mux, explicit-select or round-robin.
//            Optional transfer counter enabled by MUX_XFER_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_nto1_stream
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 16,
    parameter int SELW  = clog2_min1(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SELW-1:0]    sel,
    input  logic               mode,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready
`ifdef MUX_XFER_CNT_EN
    ,
    output logic [15:0]        xfer_cnt
`endif
);

    logic [WIDTH-1:0] r_out_data_q,   w_out_data_d;
    logic             r_out_valid_q,  w_out_valid_d;
    logic [SELW-1:0]  r_last_grant_q, w_last_grant_d;

    logic             w_free;
    logic             w_rr_valid;
    logic [SELW-1:0]  w_rr_idx;
    logic             w_grant_valid;
    logic [SELW-1:0]  w_grant_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sel_data;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_arbiter (
        .req         (in_valid),
        .last_grant  (r_last_grant_q),
        .grant_valid (w_rr_valid),
        .grant_idx   (w_rr_idx)
    );

    assign w_free = !r_out_valid_q || out_ready;

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        if (mode == MODE_RR) begin
            w_grant_valid = w_rr_valid;
            w_grant_idx   = w_rr_idx;
        end else begin
            // Out-of-range select (non-power-of-2 N) silently grants nobody.
            w_grant_valid = (int'(sel) < N);
            w_grant_idx   = sel;
        end
    end

    generate
        for (genvar i = 0; i < N; i++) begin : g_ready
            assign in_ready[i] = !rst && w_free && w_grant_valid
                                 && (w_grant_idx == SELW'(i));
        end
    endgenerate

    assign w_xfer = |(in_valid & in_ready);

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (in_ready[i]) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_out_data_d   = r_out_data_q;
        w_out_valid_d  = r_out_valid_q;
        w_last_grant_d = r_last_grant_q;
        if (w_xfer) begin
            w_out_data_d  = w_sel_data;
            w_out_valid_d = 1'b1;
            if (mode == MODE_RR) begin
                w_last_grant_d = w_grant_idx;
            end
        end else if (r_out_valid_q && out_ready) begin
            w_out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data_q   <= '0;
            r_out_valid_q  <= 1'b0;
            r_last_grant_q <= SELW'(N - 1);
        end else begin
            r_out_data_q   <= w_out_data_d;
            r_out_valid_q  <= w_out_valid_d;
            r_last_grant_q <= w_last_grant_d;
        end
    end

    assign out_data  = r_out_data_q;
    assign out_valid = r_out_valid_q;

`ifdef MUX_XFER_CNT_EN
    logic [15:0] r_xfer_cnt_q, w_xfer_cnt_d;

    always_comb begin
        w_xfer_cnt_d = r_xfer_cnt_q;
        if (w_xfer) begin
            w_xfer_cnt_d = r_xfer_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_cnt_q <= 16'd0;
        end else begin
            r_xfer_cnt_q <= w_xfer_cnt_d;
        end
    end

    assign xfer_cnt = r_xfer_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_nto1_stream.sv
// ============================================================================
// Module   : tb_mux_nto1_stream
// Brief    : Directed bench with a cycle-level reference model for the mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_nto1_stream;

    localparam int N     = 4;
    localparam int WIDTH = 16;
    localparam int SELW  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SELW-1:0]    sel;
    logic               mode;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
`ifdef MUX_XFER_CNT_EN
    logic [15:0]        xfer_cnt;
`endif

    mux_nto1_stream #(
        .N     (N),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX_XFER_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Reference state: the word the consumer should currently see.
    bit          m_valid;
    logic [15:0] m_data;
    int          m_last;
    int          m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ch_word(input int c);
        logic [N*WIDTH-1:0] d;
        d = in_data;
        return d[c*WIDTH +: WIDTH];
    endfunction

    function automatic int model_grant();
        int c;
        if (mode == 1'b0) begin
            return (int'(sel) < N) ? int'(sel) : -1;
        end
        for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = model_grant();
        if (!rst && (!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        int g;
        g = model_grant();
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_last  = N - 1;
            m_cnt   = 0;
        end else if ((!m_valid || out_ready) && g >= 0 && in_valid[g]) begin
            m_valid = 1'b1;
            m_data  = ch_word(g);
            m_cnt   = (m_cnt + 1) % 65536;
            if (mode) m_last = g;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_out_valid", 32'(out_valid), 32'(m_valid));
            chk("model_out_data", 32'(out_data), 32'(m_data));
            chk("model_in_ready", 32'(in_ready), 32'(model_ready()));
`ifdef MUX_XFER_CNT_EN
            chk("model_xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] rr_exp [6] = '{16'hAAAA, 16'h5555, 16'hFFFF, 16'hA5A5, 16'hAAAA, 16'h5555};

    initial begin
        in_data   = {16'hA5A5, 16'hFFFF, 16'h5555, 16'hAAAA};
        rst       = 1'b1;
        in_valid  = '0;
        sel       = '0;
        mode      = 1'b0;
        out_ready = 1'b1;
        cyc();
        cyc();
        chk_en = 1'b1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);

        // Explicit select, single valid channel.
        rst      = 1'b0;
        in_valid = 4'b0001;
        #1;
        chk("t1_in_ready", 32'(in_ready), 32'h1);
        cyc();
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_data", 32'(out_data), 32'hAAAA);

        // Explicit select switching channel.
        in_valid = 4'b1111;
        cyc();
        chk("t2_data0", 32'(out_data), 32'hAAAA);
        sel = 2'd2;
        #1;
        chk("t2_in_ready", 32'(in_ready), 32'h4);
        cyc();
        chk("t2_data1", 32'(out_data), 32'hFFFF);

        // Round-robin, all valid: pointer still at reset value.
        mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("t3_valid", 32'(out_valid), 32'd1);
            chk("t3_data", 32'(out_data), 32'(rr_exp[i]));
        end

        // Backpressure with sparse requests, after re-arming the pointer.
        rst      = 1'b1;
        in_valid = 4'b0000;
        cyc();
        rst      = 1'b0;
        in_valid = 4'b1010;
        cyc();
        chk("t4_first", 32'(out_data), 32'h5555);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                mode = 1'b0;
                sel  = 2'd3;
            end
            #1;
            chk("t4_hold_ready", 32'(in_ready), 32'd0);
            cyc();
            chk("t4_hold_data", 32'(out_data), 32'h5555);
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
        end
        mode      = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk("t4_release0", 32'(out_data), 32'hA5A5);
        cyc();
        chk("t4_release1", 32'(out_data), 32'h5555);

        // Reset on an edge where a transfer would otherwise occur.
        in_valid = 4'b1111;
        cyc();
        rst = 1'b1;
        cyc();
        chk("t5_valid", 32'(out_valid), 32'd0);
`ifdef MUX_XFER_CNT_EN
        chk("t5_cnt", 32'(xfer_cnt), 32'd0);
`endif
        rst = 1'b0;
        cyc();
        chk("t5_restart", 32'(out_data), 32'hAAAA);

`ifdef MUX_XFER_CNT_EN
        // Counter wrap after 65537 accepted transfers.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (65537) cyc();
        in_valid = 4'b0000;
        chk("t6_wrap", 32'(xfer_cnt), 32'h1);
`endif

        in_valid = 4'b0000;
        cyc();
        cyc();
        chk("final_idle", 32'(out_valid), 32'd0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
